// File: rtl/mc8051_intc_pkg.sv
// Shared types and constants for the mc8051 interrupt controller.
package mc8051_intc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic PRIO_LOW  = 1'b0;
    localparam logic PRIO_HIGH = 1'b1;

    localparam int unsigned SO_NUM_W = 8;
    localparam int unsigned IDX_W    = 5;

endpackage

// File: rtl/mc8051_intc_prio_enc.sv
// Lowest-index find-first-set over NUM_SRC request bits.
module mc8051_intc_prio_enc
    import mc8051_intc_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        logic found;
        found = 1'b0;
        idx_o = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (req_i[i] && !found) begin
                found = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/mc8051_intc.sv
// Two-level 8051-style interrupt controller driving the core's single
// req/ack/so_num/reti handshake, with per-source latching and nesting.
module mc8051_intc
    import mc8051_intc_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_SRC-1:0]  i_src_req,
    input  logic [NUM_SRC-1:0]  i_src_en,
    input  logic [NUM_SRC-1:0]  i_src_prio,
    input  logic [NUM_SRC-1:0]  i_src_edge,
    input  logic                i_global_en,
    output logic                o_int_req_n,
    input  logic                i_int_ack_n,
    output logic [SO_NUM_W-1:0] o_int_so_num,
    input  logic                i_int_reti,
    output logic [NUM_SRC-1:0]  o_pending,
    output logic [1:0]          o_in_service
);

    state_e             state_q;
    logic               req_n_q;
    logic               prio_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] edge_pend_q, edge_pend_d;
    logic [1:0]         in_service_q, in_service_d;

    logic [NUM_SRC-1:0] pending, eligible, hi_vec, lo_vec, ack_clr;
    logic               hi_valid, lo_valid, win_prio, ack_take;
    logic [IDX_W-1:0]   hi_idx, lo_idx, win_idx;

    assign ack_take = (state_q == REQ) && !i_int_ack_n;

    // Edge sources read the latch, level sources pass straight through.
    assign pending = (i_src_edge & edge_pend_q) | (~i_src_edge & i_src_req);

    always_comb begin
        ack_clr = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            ack_clr[i] = ack_take && (idx_q == IDX_W'(i));
        end
        edge_pend_d = i_src_edge & ((i_src_req & ~prev_q) | (edge_pend_q & ~ack_clr));
    end

    always_comb begin
        eligible = pending & i_src_en & {NUM_SRC{i_global_en}};
        if (in_service_q[1]) begin
            eligible = '0;
        end
        hi_vec = eligible & i_src_prio;
        lo_vec = in_service_q[0] ? '0 : (eligible & ~i_src_prio);
    end

    mc8051_intc_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc_hi (
        .req_i   (hi_vec),
        .valid_o (hi_valid),
        .idx_o   (hi_idx)
    );

    mc8051_intc_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc_lo (
        .req_i   (lo_vec),
        .valid_o (lo_valid),
        .idx_o   (lo_idx)
    );

    assign win_idx  = hi_valid ? hi_idx : lo_idx;
    assign win_prio = hi_valid ? PRIO_HIGH : PRIO_LOW;

    // RETI clears the innermost level before a same-cycle ack sets its level.
    always_comb begin
        in_service_d = in_service_q;
        if (i_int_reti) begin
            if (in_service_q[1]) begin
                in_service_d[1] = 1'b0;
            end else begin
                in_service_d[0] = 1'b0;
            end
        end
        if (ack_take) begin
            in_service_d[prio_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_n_q      <= 1'b1;
            prio_q       <= PRIO_LOW;
            idx_q        <= '0;
            prev_q       <= '0;
            edge_pend_q  <= '0;
            in_service_q <= '0;
        end else begin
            prev_q       <= i_src_req;
            edge_pend_q  <= edge_pend_d;
            in_service_q <= in_service_d;
            case (state_q)
                IDLE: begin
                    if (hi_valid || lo_valid) begin
                        idx_q   <= win_idx;
                        prio_q  <= win_prio;
                        req_n_q <= 1'b0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (!i_int_ack_n) begin
                        req_n_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_int_req_n  = req_n_q;
    assign o_int_so_num = {{(SO_NUM_W - IDX_W){1'b0}}, idx_q};
    assign o_pending    = pending;
    assign o_in_service = in_service_q;

endmodule
